// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the data SRAM's AXI-lite style slave port between the instruction
//   fetch unit (read-only) and the load/store unit (read/write). One
//   transaction is granted at a time. The granted master's channels are
//   forwarded combinationally to the slave. A watchdog aborts transactions
//   the slave never completes and returns a SLVERR response to the owner.
//
// Parameters
//   ADDR_WIDTH, DATA_WIDTH, STRB_WIDTH : bus widths
//   TIMEOUT : cycles in a grant state before the watchdog fires. 0 disables
//             the watchdog. Only the low 16 bits are significant.
//
// Ports
//   clk, rst_n        : single clock; asynchronous active-low reset
//   ifu_ar*/ifu_r*    : IFU read address / read data channels
//   lsu_ar*/lsu_r*    : LSU read address / read data channels
//   lsu_aw*/lsu_w*/lsu_b* : LSU write address / write data / write response
//   s_*               : forwarded channels to the SRAM slave
//   grant             : one-hot {lsu_wr, lsu_rd, ifu_rd}; 0 in IDLE and ERR
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // IFU read channels
  input  logic [ADDR_WIDTH-1:0] ifu_araddr,
  input  logic                  ifu_arvalid,
  output logic                  ifu_arready,
  output logic [DATA_WIDTH-1:0] ifu_rdata,
  output logic [1:0]            ifu_rresp,
  output logic                  ifu_rvalid,
  input  logic                  ifu_rready,
  // LSU read channels
  input  logic [ADDR_WIDTH-1:0] lsu_araddr,
  input  logic                  lsu_arvalid,
  output logic                  lsu_arready,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic [1:0]            lsu_rresp,
  output logic                  lsu_rvalid,
  input  logic                  lsu_rready,
  // LSU write channels
  input  logic [ADDR_WIDTH-1:0] lsu_awaddr,
  input  logic                  lsu_awvalid,
  output logic                  lsu_awready,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  input  logic [STRB_WIDTH-1:0] lsu_wstrb,
  input  logic                  lsu_wvalid,
  output logic                  lsu_wready,
  output logic [1:0]            lsu_bresp,
  output logic                  lsu_bvalid,
  input  logic                  lsu_bready,
  // Slave channels
  output logic [ADDR_WIDTH-1:0] s_araddr,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  output logic [ADDR_WIDTH-1:0] s_awaddr,
  output logic                  s_awvalid,
  input  logic                  s_awready,
  output logic [DATA_WIDTH-1:0] s_wdata,
  output logic [STRB_WIDTH-1:0] s_wstrb,
  output logic                  s_wvalid,
  input  logic                  s_wready,
  input  logic [1:0]            s_bresp,
  input  logic                  s_bvalid,
  output logic                  s_bready,
  // Grant indication
  output logic [2:0]            grant
);

  typedef enum logic [2:0] {
    IDLE,
    IFU_RD,
    LSU_RD,
    LSU_WR,
    ERR
  } state_t;

  localparam logic [1:0] OWN_NONE   = 2'd0;
  localparam logic [1:0] OWN_IFU_RD = 2'd1;
  localparam logic [1:0] OWN_LSU_RD = 2'd2;
  localparam logic [1:0] OWN_LSU_WR = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] GNT_IFU_RD = 3'b001;
  localparam logic [2:0] GNT_LSU_RD = 3'b010;
  localparam logic [2:0] GNT_LSU_WR = 3'b100;

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
  localparam bit          WDOG_EN     = (TIMEOUT != 0);

  state_t      state;
  logic [1:0]  owner;
  logic [15:0] wdog_cnt;
  logic        ar_done;
  logic        aw_done;
  logic        w_done;
  logic        err_valid;

  logic        err_ready;
  logic [15:0] wdog_next;
  logic        timeout_hit;
  logic        ar_hs;
  logic        aw_hs;
  logic        w_hs;
  logic        rd_end;
  logic        wr_end;

  // The counter starts at 0 on the grant edge, so ERR is entered exactly
  // TIMEOUT edges after the grant. A completing handshake in the same cycle
  // wins over the watchdog.
  assign wdog_next   = wdog_cnt + 16'd1;
  assign timeout_hit = WDOG_EN && (wdog_next == TIMEOUT_CNT);

  // Handshakes are built from the forwarded slave-side signals. These signals
  // are 0 outside the relevant grant state, so no extra state qualification
  // is needed.
  assign ar_hs  = s_arvalid & s_arready;
  assign aw_hs  = s_awvalid & s_awready;
  assign w_hs   = s_wvalid & s_wready;
  assign rd_end = s_rvalid & s_rready;
  assign wr_end = s_bvalid & s_bready;

  // Channel routing. ar_done keeps a master that holds arvalid for its next
  // request from issuing a second AR inside the current transaction.
  always_comb begin
    s_araddr    = '0;
    s_arvalid   = 1'b0;
    s_rready    = 1'b0;
    s_awaddr    = '0;
    s_awvalid   = 1'b0;
    s_wdata     = '0;
    s_wstrb     = '0;
    s_wvalid    = 1'b0;
    s_bready    = 1'b0;
    ifu_arready = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = '0;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = '0;
    lsu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bresp   = '0;
    lsu_bvalid  = 1'b0;
    err_ready   = 1'b0;

    case (state)
      IFU_RD: begin
        s_araddr    = ifu_araddr;
        s_arvalid   = ifu_arvalid & ~ar_done;
        ifu_arready = s_arready & ~ar_done;
        ifu_rdata   = s_rdata;
        ifu_rresp   = s_rresp;
        ifu_rvalid  = s_rvalid;
        s_rready    = ifu_rready;
      end
      LSU_RD: begin
        s_araddr    = lsu_araddr;
        s_arvalid   = lsu_arvalid & ~ar_done;
        lsu_arready = s_arready & ~ar_done;
        lsu_rdata   = s_rdata;
        lsu_rresp   = s_rresp;
        lsu_rvalid  = s_rvalid;
        s_rready    = lsu_rready;
      end
      LSU_WR: begin
        s_awaddr    = lsu_awaddr;
        s_awvalid   = lsu_awvalid & ~aw_done;
        lsu_awready = s_awready & ~aw_done;
        s_wdata     = lsu_wdata;
        s_wstrb     = lsu_wstrb;
        s_wvalid    = lsu_wvalid & ~w_done;
        lsu_wready  = s_wready & ~w_done;
        lsu_bresp   = s_bresp;
        lsu_bvalid  = s_bvalid;
        s_bready    = lsu_bready;
      end
      ERR: begin
        // The slave is fully disconnected here. A late response is dropped
        // because its ready is never raised.
        case (owner)
          OWN_IFU_RD: begin
            ifu_rvalid = err_valid;
            ifu_rresp  = err_valid ? RESP_SLVERR : RESP_OKAY;
            err_ready  = ifu_rready;
          end
          OWN_LSU_RD: begin
            lsu_rvalid = err_valid;
            lsu_rresp  = err_valid ? RESP_SLVERR : RESP_OKAY;
            err_ready  = lsu_rready;
          end
          OWN_LSU_WR: begin
            lsu_bvalid = err_valid;
            lsu_bresp  = err_valid ? RESP_SLVERR : RESP_OKAY;
            err_ready  = lsu_bready;
          end
          default: err_ready = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  // Arbitration, transaction tracking, watchdog and error response. grant
  // and err_valid are registered alongside the state. The error response
  // therefore appears one cycle after ERR is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= OWN_NONE;
      wdog_cnt  <= '0;
      ar_done   <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      err_valid <= 1'b0;
      grant     <= '0;
    end else begin
      case (state)
        IDLE: begin
          wdog_cnt  <= '0;
          ar_done   <= 1'b0;
          aw_done   <= 1'b0;
          w_done    <= 1'b0;
          err_valid <= 1'b0;
          if (lsu_awvalid) begin
            state <= LSU_WR;
            owner <= OWN_LSU_WR;
            grant <= GNT_LSU_WR;
          end else if (lsu_arvalid) begin
            state <= LSU_RD;
            owner <= OWN_LSU_RD;
            grant <= GNT_LSU_RD;
          end else if (ifu_arvalid) begin
            state <= IFU_RD;
            owner <= OWN_IFU_RD;
            grant <= GNT_IFU_RD;
          end else begin
            owner <= OWN_NONE;
            grant <= '0;
          end
        end

        IFU_RD, LSU_RD: begin
          if (rd_end) begin
            state   <= IDLE;
            owner   <= OWN_NONE;
            grant   <= '0;
            ar_done <= 1'b0;
          end else if (timeout_hit) begin
            state   <= ERR;
            grant   <= '0;
            ar_done <= 1'b0;
          end else begin
            wdog_cnt <= wdog_next;
            if (ar_hs) begin
              ar_done <= 1'b1;
            end
          end
        end

        LSU_WR: begin
          if (wr_end) begin
            state   <= IDLE;
            owner   <= OWN_NONE;
            grant   <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else if (timeout_hit) begin
            state   <= ERR;
            grant   <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            wdog_cnt <= wdog_next;
            if (aw_hs) begin
              aw_done <= 1'b1;
            end
            if (w_hs) begin
              w_done <= 1'b1;
            end
          end
        end

        ERR: begin
          grant <= '0;
          if (!err_valid) begin
            err_valid <= 1'b1;
          end else if (err_ready) begin
            err_valid <= 1'b0;
            owner     <= OWN_NONE;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          owner     <= OWN_NONE;
          grant     <= '0;
          err_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Two arbiter instances share every input: dut (TIMEOUT=4) and dut_nt
//   (TIMEOUT=0, watchdog disabled). Directed stimulus pushes the expected
//   master-side responses into one queue per instance. A monitor pops from
//   that queue on every completed response handshake. Point checks cover
//   grant, forwarding and reset behaviour.
module tb_mem_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 8;

  localparam logic [1:0] CH_IFU_R = 2'd0;
  localparam logic [1:0] CH_LSU_R = 2'd1;
  localparam logic [1:0] CH_LSU_B = 2'd2;

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] data;
    logic [1:0]  resp;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // shared inputs
  logic [AW-1:0] ifu_araddr;
  logic          ifu_arvalid;
  logic          ifu_rready;
  logic [AW-1:0] lsu_araddr;
  logic          lsu_arvalid;
  logic          lsu_rready;
  logic [AW-1:0] lsu_awaddr;
  logic          lsu_awvalid;
  logic [DW-1:0] lsu_wdata;
  logic [SW-1:0] lsu_wstrb;
  logic          lsu_wvalid;
  logic          lsu_bready;
  logic          s_arready;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic          s_rvalid;
  logic          s_awready;
  logic          s_wready;
  logic [1:0]    s_bresp;
  logic          s_bvalid;

  // per-instance outputs, index 0 = dut, 1 = dut_nt
  logic          o_ifu_arready [2];
  logic [DW-1:0] o_ifu_rdata   [2];
  logic [1:0]    o_ifu_rresp   [2];
  logic          o_ifu_rvalid  [2];
  logic          o_lsu_arready [2];
  logic [DW-1:0] o_lsu_rdata   [2];
  logic [1:0]    o_lsu_rresp   [2];
  logic          o_lsu_rvalid  [2];
  logic          o_lsu_awready [2];
  logic          o_lsu_wready  [2];
  logic [1:0]    o_lsu_bresp   [2];
  logic          o_lsu_bvalid  [2];
  logic [AW-1:0] o_s_araddr    [2];
  logic          o_s_arvalid   [2];
  logic          o_s_rready    [2];
  logic [AW-1:0] o_s_awaddr    [2];
  logic          o_s_awvalid   [2];
  logic [DW-1:0] o_s_wdata     [2];
  logic [SW-1:0] o_s_wstrb     [2];
  logic          o_s_wvalid    [2];
  logic          o_s_bready    [2];
  logic [2:0]    o_grant       [2];

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(o_ifu_arready[0]),
    .ifu_rdata(o_ifu_rdata[0]), .ifu_rresp(o_ifu_rresp[0]), .ifu_rvalid(o_ifu_rvalid[0]),
    .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(o_lsu_arready[0]),
    .lsu_rdata(o_lsu_rdata[0]), .lsu_rresp(o_lsu_rresp[0]), .lsu_rvalid(o_lsu_rvalid[0]),
    .lsu_rready(lsu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(o_lsu_awready[0]),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid),
    .lsu_wready(o_lsu_wready[0]),
    .lsu_bresp(o_lsu_bresp[0]), .lsu_bvalid(o_lsu_bvalid[0]), .lsu_bready(lsu_bready),
    .s_araddr(o_s_araddr[0]), .s_arvalid(o_s_arvalid[0]), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(o_s_rready[0]),
    .s_awaddr(o_s_awaddr[0]), .s_awvalid(o_s_awvalid[0]), .s_awready(s_awready),
    .s_wdata(o_s_wdata[0]), .s_wstrb(o_s_wstrb[0]), .s_wvalid(o_s_wvalid[0]),
    .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(o_s_bready[0]),
    .grant(o_grant[0])
  );

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .TIMEOUT(0)) dut_nt (
    .clk(clk), .rst_n(rst_n),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(o_ifu_arready[1]),
    .ifu_rdata(o_ifu_rdata[1]), .ifu_rresp(o_ifu_rresp[1]), .ifu_rvalid(o_ifu_rvalid[1]),
    .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(o_lsu_arready[1]),
    .lsu_rdata(o_lsu_rdata[1]), .lsu_rresp(o_lsu_rresp[1]), .lsu_rvalid(o_lsu_rvalid[1]),
    .lsu_rready(lsu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(o_lsu_awready[1]),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid),
    .lsu_wready(o_lsu_wready[1]),
    .lsu_bresp(o_lsu_bresp[1]), .lsu_bvalid(o_lsu_bvalid[1]), .lsu_bready(lsu_bready),
    .s_araddr(o_s_araddr[1]), .s_arvalid(o_s_arvalid[1]), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(o_s_rready[1]),
    .s_awaddr(o_s_awaddr[1]), .s_awvalid(o_s_awvalid[1]), .s_awready(s_awready),
    .s_wdata(o_s_wdata[1]), .s_wstrb(o_s_wstrb[1]), .s_wvalid(o_s_wvalid[1]),
    .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(o_s_bready[1]),
    .grant(o_grant[1])
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  rsp_t exp_q [2][$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic expectRsp(input int inst, input logic [1:0] ch,
                           input logic [31:0] data, input logic [1:0] resp);
    rsp_t e;
    e.ch   = ch;
    e.data = data;
    e.resp = resp;
    exp_q[inst].push_back(e);
  endtask

  task automatic scoreCheck(input int inst, input logic [1:0] ch,
                            input logic [31:0] data, input logic [1:0] resp);
    rsp_t e;
    n_checks++;
    if (exp_q[inst].size() == 0) begin
      n_fail++;
      $display("[TB] FAIL inst%0d unexpected_rsp: got ch=%0d data=%h resp=%0d, expected none",
               inst, ch, data, resp);
    end else begin
      e = exp_q[inst].pop_front();
      if (e.ch !== ch || e.data !== data || e.resp !== resp) begin
        n_fail++;
        $display("[TB] FAIL inst%0d rsp: got ch=%0d data=%h resp=%0d, expected ch=%0d data=%h resp=%0d",
                 inst, ch, data, resp, e.ch, e.data, e.resp);
      end
    end
  endtask

  // Monitor: every completed response handshake on a master port is scored.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (o_ifu_rvalid[i] && ifu_rready)
        scoreCheck(i, CH_IFU_R, o_ifu_rdata[i], o_ifu_rresp[i]);
      if (o_lsu_rvalid[i] && lsu_rready)
        scoreCheck(i, CH_LSU_R, o_lsu_rdata[i], o_lsu_rresp[i]);
      if (o_lsu_bvalid[i] && lsu_bready)
        scoreCheck(i, CH_LSU_B, 32'd0, o_lsu_bresp[i]);
    end
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no completion, expected finish");
    $fatal(1, "[TB] simulation time bound expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    ifu_araddr = '0; ifu_arvalid = 1'b0; ifu_rready = 1'b0;
    lsu_araddr = '0; lsu_arvalid = 1'b0; lsu_rready = 1'b0;
    lsu_awaddr = '0; lsu_awvalid = 1'b0; lsu_wdata = '0; lsu_wstrb = '0;
    lsu_wvalid = 1'b0; lsu_bready = 1'b0;
    s_arready = 1'b0; s_rdata = '0; s_rresp = '0; s_rvalid = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0; s_bresp = '0; s_bvalid = 1'b0;
  endtask

  // Leaves the bench just after a posedge with reset released ("cycle 0").
  task automatic doReset();
    idleInputs();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Drives the master request channels for the coming cycle.
  task automatic applyStimulus(input logic ifu_v, input logic [31:0] ifu_a,
                               input logic lrd_v, input logic [31:0] lrd_a,
                               input logic lwr_v, input logic [31:0] lwr_a,
                               input logic [31:0] wd, input logic [7:0] ws);
    ifu_arvalid = ifu_v; ifu_araddr = ifu_a;
    lsu_arvalid = lrd_v; lsu_araddr = lrd_a;
    lsu_awvalid = lwr_v; lsu_awaddr = lwr_a;
    lsu_wvalid  = lwr_v; lsu_wdata  = wd; lsu_wstrb = ws;
  endtask

  initial begin
    idleInputs();
    #2;
    checkOutput("reset_grant", 32'(o_grant[0]), 32'd0);

    // Test 1: single IFU read with a zero-wait slave
    doReset();
    applyStimulus(1'b1, 32'h0000_0100, 1'b0, '0, 1'b0, '0, '0, '0);
    s_arready = 1'b1; ifu_rready = 1'b1;
    @(negedge clk);
    checkOutput("t1_c0_s_arvalid", 32'(o_s_arvalid[0]), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("t1_c1_s_arvalid", 32'(o_s_arvalid[0]), 32'd1);
    checkOutput("t1_c1_s_araddr", o_s_araddr[0], 32'h0000_0100);
    checkOutput("t1_c1_grant", 32'(o_grant[0]), 32'b001);
    checkOutput("t1_c1_ifu_arready", 32'(o_ifu_arready[0]), 32'd1);
    tick();
    ifu_arvalid = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b00;
    expectRsp(0, CH_IFU_R, 32'hDEAD_BEEF, 2'b00);
    expectRsp(1, CH_IFU_R, 32'hDEAD_BEEF, 2'b00);
    tick();
    s_rvalid = 1'b0;
    @(negedge clk);
    checkOutput("t1_c3_grant_idle", 32'(o_grant[0]), 32'd0);
    checkOutput("t1_c3_ifu_rvalid", 32'(o_ifu_rvalid[0]), 32'd0);

    // Test 2: simultaneous IFU read and LSU store; the store wins
    doReset();
    applyStimulus(1'b1, 32'h0000_0200, 1'b0, '0, 1'b1, 32'h8000_0010,
                  32'hCAFE_F00D, 8'h0F);
    s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
    lsu_bready = 1'b1; ifu_rready = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("t2_c1_grant", 32'(o_grant[0]), 32'b100);
    checkOutput("t2_c1_s_awaddr", o_s_awaddr[0], 32'h8000_0010);
    checkOutput("t2_c1_s_wstrb", 32'(o_s_wstrb[0]), 32'h0F);
    checkOutput("t2_c1_s_wdata", o_s_wdata[0], 32'hCAFE_F00D);
    checkOutput("t2_c1_s_arvalid", 32'(o_s_arvalid[0]), 32'd0);
    checkOutput("t2_c1_ifu_arready", 32'(o_ifu_arready[0]), 32'd0);
    tick();
    lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
    s_bvalid = 1'b1; s_bresp = 2'b00;
    expectRsp(0, CH_LSU_B, 32'd0, 2'b00);
    expectRsp(1, CH_LSU_B, 32'd0, 2'b00);
    @(negedge clk);
    checkOutput("t2_c2_ifu_arready", 32'(o_ifu_arready[0]), 32'd0);
    tick();
    s_bvalid = 1'b0;
    @(negedge clk);
    checkOutput("t2_c3_grant_idle", 32'(o_grant[0]), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("t2_c4_grant", 32'(o_grant[0]), 32'b001);
    checkOutput("t2_c4_s_araddr", o_s_araddr[0], 32'h0000_0200);
    tick();
    ifu_arvalid = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h1111_2222;
    expectRsp(0, CH_IFU_R, 32'h1111_2222, 2'b00);
    expectRsp(1, CH_IFU_R, 32'h1111_2222, 2'b00);
    tick();
    s_rvalid = 1'b0;

    // Test 3: W accepted two cycles before AW; master keeps both valids high
    doReset();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 32'h8000_0020, 32'h55AA_55AA, 8'hFF);
    s_wready = 1'b1; lsu_bready = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("t3_c1_s_wvalid", 32'(o_s_wvalid[0]), 32'd1);
    checkOutput("t3_c1_s_awvalid", 32'(o_s_awvalid[0]), 32'd1);
    checkOutput("t3_c1_lsu_wready", 32'(o_lsu_wready[0]), 32'd1);
    tick();
    s_wready = 1'b0;
    @(negedge clk);
    checkOutput("t3_c2_s_wvalid", 32'(o_s_wvalid[0]), 32'd0);
    checkOutput("t3_c2_s_awvalid", 32'(o_s_awvalid[0]), 32'd1);
    checkOutput("t3_c2_lsu_awready", 32'(o_lsu_awready[0]), 32'd0);
    tick();
    s_awready = 1'b1;
    @(negedge clk);
    checkOutput("t3_c3_s_awvalid", 32'(o_s_awvalid[0]), 32'd1);
    checkOutput("t3_c3_s_wvalid", 32'(o_s_wvalid[0]), 32'd0);
    tick();
    s_awready = 1'b0;
    s_bvalid = 1'b1; s_bresp = 2'b00;
    expectRsp(0, CH_LSU_B, 32'd0, 2'b00);
    expectRsp(1, CH_LSU_B, 32'd0, 2'b00);
    @(negedge clk);
    checkOutput("t3_c4_s_awvalid", 32'(o_s_awvalid[0]), 32'd0);
    checkOutput("t3_c4_s_wvalid", 32'(o_s_wvalid[0]), 32'd0);
    tick();
    s_bvalid = 1'b0; lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
    @(negedge clk);
    checkOutput("t3_c5_grant_idle", 32'(o_grant[0]), 32'd0);

    // Test 4: TIMEOUT=4, slave never answers an LSU load in time
    doReset();
    applyStimulus(1'b0, '0, 1'b1, 32'h0000_0300, 1'b0, '0, '0, '0);
    s_arready = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("t4_c1_grant", 32'(o_grant[0]), 32'b010);
    checkOutput("t4_c1_s_araddr", o_s_araddr[0], 32'h0000_0300);
    tick();
    lsu_arvalid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    checkOutput("t4_c4_grant", 32'(o_grant[0]), 32'b010);
    tick();
    s_rvalid = 1'b1; s_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    checkOutput("t4_c5_grant_err", 32'(o_grant[0]), 32'd0);
    checkOutput("t4_c5_lsu_rvalid", 32'(o_lsu_rvalid[0]), 32'd0);
    checkOutput("t4_c5_nt_grant", 32'(o_grant[1]), 32'b010);
    tick();
    @(negedge clk);
    checkOutput("t4_c6_lsu_rvalid", 32'(o_lsu_rvalid[0]), 32'd1);
    checkOutput("t4_c6_lsu_rresp", 32'(o_lsu_rresp[0]), 32'd2);
    checkOutput("t4_c6_lsu_rdata", o_lsu_rdata[0], 32'd0);
    tick();
    lsu_rready = 1'b1;
    expectRsp(0, CH_LSU_R, 32'd0, 2'b10);
    expectRsp(1, CH_LSU_R, 32'hBAD0_BAD0, 2'b00);
    @(negedge clk);
    checkOutput("t4_c7_s_rready_err", 32'(o_s_rready[0]), 32'd0);
    checkOutput("t4_c7_nt_s_rready", 32'(o_s_rready[1]), 32'd1);
    tick();
    s_rvalid = 1'b0; lsu_rready = 1'b0;
    @(negedge clk);
    checkOutput("t4_c8_lsu_rvalid", 32'(o_lsu_rvalid[0]), 32'd0);

    // Test 5: asynchronous reset in the middle of an LSU read
    doReset();
    applyStimulus(1'b0, '0, 1'b1, 32'h0000_0400, 1'b0, '0, '0, '0);
    s_arready = 1'b1;
    tick();
    tick();
    lsu_arvalid = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h7777_7777;
    @(negedge clk);
    checkOutput("t5_pre_lsu_rvalid", 32'(o_lsu_rvalid[0]), 32'd1);
    checkOutput("t5_pre_lsu_rdata", o_lsu_rdata[0], 32'h7777_7777);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_lsu_rvalid", 32'(o_lsu_rvalid[0]), 32'd0);
    checkOutput("t5_rst_lsu_rdata", o_lsu_rdata[0], 32'd0);
    checkOutput("t5_rst_s_arvalid", 32'(o_s_arvalid[0]), 32'd0);
    checkOutput("t5_rst_s_araddr", o_s_araddr[0], 32'd0);
    checkOutput("t5_rst_grant", 32'(o_grant[0]), 32'd0);
    checkOutput("t5_rst_nt_lsu_rvalid", 32'(o_lsu_rvalid[1]), 32'd0);
    s_rvalid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'h0000_0600, 1'b0, '0, 1'b0, '0, '0, '0);
    ifu_rready = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("t5_c1_grant", 32'(o_grant[0]), 32'b001);
    tick();
    ifu_arvalid = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h600D_DA7A;
    expectRsp(0, CH_IFU_R, 32'h600D_DA7A, 2'b00);
    expectRsp(1, CH_IFU_R, 32'h600D_DA7A, 2'b00);
    tick();
    s_rvalid = 1'b0;

    // Test 6: 1000-cycle slave stall; only the TIMEOUT=4 instance errors
    doReset();
    applyStimulus(1'b0, '0, 1'b1, 32'h0000_0500, 1'b0, '0, '0, '0);
    s_arready = 1'b1; lsu_rready = 1'b1;
    tick();
    tick();
    lsu_arvalid = 1'b0; s_arready = 1'b0;
    expectRsp(0, CH_LSU_R, 32'd0, 2'b10);
    repeat (1000) tick();
    @(negedge clk);
    checkOutput("t6_nt_grant_stall", 32'(o_grant[1]), 32'b010);
    checkOutput("t6_grant_after_err", 32'(o_grant[0]), 32'd0);
    tick();
    s_rvalid = 1'b1; s_rdata = 32'h1357_9BDF; s_rresp = 2'b00;
    expectRsp(1, CH_LSU_R, 32'h1357_9BDF, 2'b00);
    @(negedge clk);
    checkOutput("t6_s_rready_idle", 32'(o_s_rready[0]), 32'd0);
    tick();
    s_rvalid = 1'b0; lsu_rready = 1'b0;
    @(negedge clk);
    checkOutput("t6_nt_grant_done", 32'(o_grant[1]), 32'd0);

    repeat (3) tick();
    checkOutput("dut_queue_empty", 32'(exp_q[0].size()), 32'd0);
    checkOutput("dut_nt_queue_empty", 32'(exp_q[1].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
